// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues 1-cycle-latency imem reads from pc_i, buffers {pc, inst} in a small FIFO.
// Optional head predecode enabled by defining IF_PREDECODE_EN; otherwise pd_* outputs are tied low.
module if_fetch #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 13,
  parameter int unsigned IW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          flush_i,
  input  logic          id_hold_i,
  output logic [AW-1:0] imem_addr_o,
  output logic          imem_rd_en_o,
  input  logic [IW-1:0] imem_data_i,
  output logic [IW-1:0] inst_o,
  output logic [AW-1:0] inst_pc_o,
  output logic          inst_valid_o,
  output logic          fetch_hold_o,
  output logic          pd_jump_o,
  output logic          pd_cjump_o,
  output logic          pd_call_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [IW-1:0] buf_inst [DEPTH];
  logic [AW-1:0] buf_pc   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  logic          pend;
  logic [AW-1:0] pend_pc;

  logic          pop_c, push_c, issue_c;
  logic [CW:0]   credit_c;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Issue credit: slots already committed (stored + in flight) minus what leaves this cycle.
  always_comb begin
    pop_c    = inst_valid_o & ~id_hold_i;
    push_c   = pend & ~flush_i;
    credit_c = (CW+1)'(occ) + (CW+1)'(pend) - (CW+1)'(pop_c);
    issue_c  = ~rst & ~flush_i & (credit_c < (CW+1)'(DEPTH));
  end

  assign imem_addr_o  = pc_i;
  assign imem_rd_en_o = issue_c;
  assign fetch_hold_o = ~rst & ~flush_i & ~issue_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= '0;
      pend    <= 1'b0;
      pend_pc <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (flush_i) begin
      // Flush drops stored words and the returning read; no read issues this cycle.
      occ    <= '0;
      pend   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) begin
        buf_inst[wr_ptr] <= imem_data_i;
        buf_pc[wr_ptr]   <= pend_pc;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop_c) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      occ  <= occ + CW'(push_c) - CW'(pop_c);
      pend <= issue_c;
      if (issue_c) begin
        pend_pc <= pc_i;
      end
    end
  end

  assign inst_valid_o = (occ != '0);
  assign inst_o       = buf_inst[rd_ptr];
  assign inst_pc_o    = buf_pc[rd_ptr];

`ifdef IF_PREDECODE_EN
  logic [2:0] op_c;
  assign op_c       = inst_o[IW-1 -: 3];
  assign pd_jump_o  = inst_valid_o & (op_c == 3'b000);
  assign pd_cjump_o = inst_valid_o & (op_c == 3'b001);
  assign pd_call_o  = inst_valid_o & (op_c == 3'b010);
`else
  assign pd_jump_o  = 1'b0;
  assign pd_cjump_o = 1'b0;
  assign pd_call_o  = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a PC-stage and sync-memory model drive the DUT; a monitor checks every consumed word.
module tb_if_fetch;
  localparam int unsigned AW    = 13;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst, flush_i, id_hold_i;
  logic [AW-1:0] pc, flush_target;
  logic [AW-1:0] imem_addr_o;
  logic          imem_rd_en_o;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_valid_o, fetch_hold_o, pd_jump_o, pd_cjump_o, pd_call_o;

  logic [IW-1:0] mem [8192];

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } exp_t;
  exp_t q[$];

  int n_pass = 0;
  int n_total = 0;
  int pops = 0;

  always #5 clk = ~clk;

  if_fetch #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .flush_i(flush_i), .id_hold_i(id_hold_i),
    .imem_addr_o(imem_addr_o), .imem_rd_en_o(imem_rd_en_o), .imem_data_i(imem_data),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .fetch_hold_o(fetch_hold_o), .pd_jump_o(pd_jump_o), .pd_cjump_o(pd_cjump_o),
    .pd_call_o(pd_call_o)
  );

  // PC stage: reset to 0, load target on flush, advance when not held.
  always @(posedge clk) begin
    if (rst) pc <= '0;
    else if (flush_i) pc <= flush_target;
    else if (!fetch_hold_o) pc <= pc + 13'd1;
  end

  always @(posedge clk) begin
    if (imem_rd_en_o) imem_data <= mem[imem_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every word decode consumes must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !flush_i && inst_valid_o && !id_hold_i) begin
      exp_t e;
      pops++;
      if (q.size() == 0) begin
        chk("sb_underflow", 32'(inst_pc_o), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sb_pc", 32'(inst_pc_o), 32'(e.pc));
        chk("sb_inst", 32'(inst_o), 32'(e.inst));
      end
    end
  end

  // Overflow guard: a return arriving into a full FIFO with nothing leaving.
  always @(negedge clk) begin
    if (!rst && !flush_i && dut.pend && int'(dut.occ) == int'(DEPTH)
        && !(inst_valid_o && !id_hold_i)) begin
      n_total++;
      $display("FAIL fifo_overflow: push with occ=%0d at %0t", dut.occ, $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_from(input logic [AW-1:0] base, input int n);
    q.delete();
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = base + AW'(i);
      e.inst = 16'hA000 + IW'(e.pc);
      q.push_back(e);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid_o), 0);
    chk({tag, "_inst"}, 32'(inst_o), 0);
    chk({tag, "_inst_pc"}, 32'(inst_pc_o), 0);
    chk({tag, "_rd_en"}, 32'(imem_rd_en_o), 0);
    chk({tag, "_hold"}, 32'(fetch_hold_o), 0);
    chk({tag, "_addr"}, 32'(imem_addr_o), 0);
    chk({tag, "_pd"}, 32'({pd_jump_o, pd_cjump_o, pd_call_o}), 0);
  endtask

  initial begin
    int p0;
    logic [15:0] pd_words [4];
    logic [2:0]  pd_exp   [4];

    for (int i = 0; i < 8192; i++) mem[i] = 16'hA000 + 16'(i);
    pd_words[0] = 16'h0123; pd_words[1] = 16'h2123;
    pd_words[2] = 16'h4123; pd_words[3] = 16'h8123;
    for (int i = 0; i < 4; i++) mem[13'h0300 + 13'(i)] = pd_words[i];
`ifdef IF_PREDECODE_EN
    pd_exp[0] = 3'b100; pd_exp[1] = 3'b010; pd_exp[2] = 3'b001; pd_exp[3] = 3'b000;
`else
    pd_exp[0] = 3'b000; pd_exp[1] = 3'b000; pd_exp[2] = 3'b000; pd_exp[3] = 3'b000;
`endif

    rst = 1'b1; flush_i = 1'b0; id_hold_i = 1'b0; flush_target = '0;
    step(); step();
    chk_all_zero("reset");

    // Free run from PC 0.
    expect_from(13'h0000, 40);
    rst = 1'b0;
    step();
    chk("run_first_edge_valid", 32'(inst_valid_o), 0);
    step();
    chk("run_first_valid", 32'(inst_valid_o), 1);
    chk("run_first_pc", 32'(inst_pc_o), 0);
    chk("run_first_inst", 32'(inst_o), 32'hA000);
    p0 = pops;
    repeat (20) step();
    chk("run_no_gaps", 32'(pops - p0), 20);
    chk("run_head_pc", 32'(inst_pc_o), 20);

    // Decode stall for 4 cycles.
    id_hold_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_head_pc", 32'(inst_pc_o), 20);
    end
    chk("stall_fetch_hold", 32'(fetch_hold_o), 1);
    chk("stall_rd_en", 32'(imem_rd_en_o), 0);
    chk("stall_valid", 32'(inst_valid_o), 1);
    id_hold_i = 1'b0;
    p0 = pops;
    repeat (10) step();
    chk("resume_count", 32'(pops - p0), 10);
    chk("resume_head_pc", 32'(inst_pc_o), 30);

    // Flush while the FIFO is full.
    id_hold_i = 1'b1;
    step(); step();
    flush_i = 1'b1; flush_target = 13'h0100; id_hold_i = 1'b0;
    step();
    flush_i = 1'b0;
    expect_from(13'h0100, 20);
    chk("flush_valid_next", 32'(inst_valid_o), 0);
    step();
    chk("flush_valid_plus1", 32'(inst_valid_o), 0);
    step();
    chk("flush_target_valid", 32'(inst_valid_o), 1);
    chk("flush_target_pc", 32'(inst_pc_o), 32'h0100);
    repeat (5) step();

    // Flush coinciding with decode stall and a returning word.
    id_hold_i = 1'b1; flush_i = 1'b1; flush_target = 13'h0200;
    step();
    flush_i = 1'b0; id_hold_i = 1'b0;
    expect_from(13'h0200, 20);
    chk("flush_hold_valid", 32'(inst_valid_o), 0);
    step();
    chk("flush_hold_no_pend", 32'(inst_valid_o), 0);
    step();
    chk("flush_hold_target_pc", 32'(inst_pc_o), 32'h0200);
    repeat (4) step();

    // Reset in the middle of a stream.
    id_hold_i = 1'b1; rst = 1'b1;
    step();
    chk_all_zero("midrst");
    expect_from(13'h0000, 20);
    rst = 1'b0; id_hold_i = 1'b0;
    step();
    chk("restart_valid0", 32'(inst_valid_o), 0);
    step();
    chk("restart_valid1", 32'(inst_valid_o), 1);
    chk("restart_pc", 32'(inst_pc_o), 0);
    repeat (5) step();

    // Predecode of head words, stepped one at a time under stall.
    flush_i = 1'b1; flush_target = 13'h0300; id_hold_i = 1'b1;
    step();
    flush_i = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.pc = 13'h0300 + 13'(i);
      e.inst = pd_words[i];
      q.push_back(e);
    end
    step(); step();
    chk("pd_valid", 32'(inst_valid_o), 1);
    for (int k = 0; k < 4; k++) begin
      chk("pd_head_pc", 32'(inst_pc_o), 32'h0300 + 32'(k));
      chk("pd_bits", 32'({pd_jump_o, pd_cjump_o, pd_call_o}), 32'(pd_exp[k]));
      if (k < 3) begin
        id_hold_i = 1'b0;
        step();
        id_hold_i = 1'b1;
      end
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
